apb_regbank_slave: RTL and testbench
====================================

# apb_regbank_slave

Parametrised APB slave fronting an internal register bank, with programmable wait states and error response. It is the next-generation replacement for the fixed 32-bit, 4-bit-address APB slave. It sits on the peripheral APB segment, and its register contents are exposed as a flat bus for control logic. Over the previous slave it adds configurable width, depth and latency, PSLVERR signalling, and optional byte strobes.

## Interface
Parameters:
- DATA_W, 32, data width; multiple of 8, at least 8.
- ADDR_W, 8, PADDR width in bits; byte addressing.
- NUM_REGS, 16, number of registers; 1..2^(ADDR_W-2).
- WAIT_CYCLES, 0, wait states inserted before PREADY; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- paddr_i  in  ADDR_W  byte address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DATA_W  write data.
- pstrb_i  in  DATA_W/8  byte strobes; present only with APB_REGBANK_PSTRB_EN.
- prdata_o  out  DATA_W  read data; valid while pready_o = 1.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid while pready_o = 1.
- regs_o  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].

## Operation
- Word index is paddr_i[ADDR_W-1:2]; paddr_i[1:0] are ignored.
- An index of NUM_REGS or above is out of range.
- FSM states:
  - IDLE: on psel_i & penable_i, go to RESP if WAIT_CYCLES == 0; otherwise go to WAIT with cnt = WAIT_CYCLES-1.
  - WAIT: decrement cnt; go to RESP when cnt == 0.
  - RESP: pready_o = 1 for exactly one cycle, then return to IDLE.
- On the edge entering RESP:
  - Read, in range: prdata_o = register value; pslverr_o = 0.
  - Out of range (read or write): prdata_o = 0; pslverr_o = 1.
  - Write: prdata_o = 0.
- Write commit happens on the edge leaving RESP, only for in-range addresses. Out-of-range writes change no register.
- Reads have no side effects.
- If psel_i or penable_i drops while in WAIT (protocol violation), the FSM returns to IDLE, commits nothing and never asserts pready_o.
- In RESP the FSM completes the transfer unconditionally.
- prdata_o and pslverr_o return to 0 on leaving RESP.
- Address and control are sampled on the IDLE→WAIT/RESP edge and held internally. Changes on the bus during WAIT are ignored.

## Timing
- Reset values: all registers, regs_o, prdata_o, pready_o and pslverr_o are 0; FSM is in IDLE.
- Reset assertion mid-transfer aborts it immediately; no write commits.
- With access phase starting in cycle T, pready_o is high in cycle T+1+WAIT_CYCLES.
- A total APB transfer takes 3+WAIT_CYCLES cycles including the setup phase.
- Write data is visible on regs_o, and to a following read, from the cycle after RESP.
- Back-to-back transfers: a new setup phase may start in the cycle following RESP.
- The bank accepts one transfer at a time.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- APB_REGBANK_PSTRB_EN defined:
  - The pstrb_i port exists.
  - On write commit, byte lane b updates only if pstrb_i[b] = 1; pstrb_i is sampled with address and control.
  - A write with pstrb_i = 0 completes with pslverr_o = 0 and changes nothing.
- Not defined: no pstrb_i port; every write replaces the full word.

## Test plan
- Reset, WAIT_CYCLES = 0: write 0xDEADBEEF to addr 0x08, then read 0x08 → pready_o in the cycle after each access phase; prdata_o = 0xDEADBEEF; regs_o[2] = 0xDEADBEEF; pslverr_o = 0.
- WAIT_CYCLES = 3: read of addr 0x04 → pready_o high exactly 4 cycles after penable_i rises, for one cycle.
- NUM_REGS = 16: write 0x12345678 to addr 0x40 → pslverr_o = 1 with pready_o; regs_o unchanged; a following read of 0x40 returns prdata_o = 0 with pslverr_o = 1.
- PSTRB_EN: reg 1 = 0xFFFFFFFF, then write 0x00000000 with pstrb_i = 4'b0101 → reg 1 = 0xFF00FF00.
- WAIT_CYCLES = 5: drop psel_i two cycles into WAIT, or assert reset mid-write → no pready_o; target register unchanged (reset case: all zero); the next transfer completes normally.

Source files
------------

// File: rtl/apb_regbank_slave_if.sv
// APB bus bundle for apb_regbank_slave; pstrb_i exists only with APB_REGBANK_PSTRB_EN.
interface apb_regbank_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              psel_i;
    logic              penable_i;
    logic [ADDR_W-1:0] paddr_i;
    logic              pwrite_i;
    logic [DATA_W-1:0] pwdata_i;
`ifdef APB_REGBANK_PSTRB_EN
    logic [STRB_W-1:0] pstrb_i;
`endif
    logic [DATA_W-1:0] prdata_o;
    logic              pready_o;
    logic              pslverr_o;

`ifdef APB_REGBANK_PSTRB_EN
    modport master (output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
                    input  prdata_o, pready_o, pslverr_o);
    modport slave  (input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
                    output prdata_o, pready_o, pslverr_o);
`else
    modport master (output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
                    input  prdata_o, pready_o, pslverr_o);
    modport slave  (input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
                    output prdata_o, pready_o, pslverr_o);
`endif
endinterface

// File: rtl/apb_regbank_slave.sv
// APB slave in front of a flat register bank with programmable wait states and PSLVERR.
// Optional byte strobes are enabled by defining APB_REGBANK_PSTRB_EN.
module apb_regbank_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    apb_regbank_slave_if.slave         bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);
    localparam int unsigned IDX_W     = ADDR_W - 2;
    localparam int unsigned IDX_EXT_W = IDX_W + 1;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q;
    logic                       write_q;
    logic [DATA_W-1:0]          wdata_q;
    logic [STRB_W-1:0]          strb_q;
    logic [NUM_REGS*DATA_W-1:0] bank_q;
    logic [DATA_W-1:0]          prdata_q, prdata_d;
    logic                       pready_q, pready_d;
    logic                       pslverr_q, pslverr_d;

    logic                       access_c;
    logic                       capture_c;
    logic                       in_range_c;
    logic                       cur_write_c;
    logic [IDX_W-1:0]           cur_idx_c;
    logic [STRB_W-1:0]          bus_strb_c;
    logic [DATA_W-1:0]          rdata_c;
    logic                       unused_c;

`ifdef APB_REGBANK_PSTRB_EN
    assign bus_strb_c = bus.pstrb_i;
`else
    assign bus_strb_c = '1;
`endif

    // Byte offset bits are not part of the word index.
    assign unused_c = ^bus.paddr_i[1:0];

    // In IDLE the response is built from the live bus; afterwards from the captured copy.
    always_comb begin
        access_c    = bus.psel_i & bus.penable_i;
        capture_c   = (state_q == IDLE) && access_c;
        cur_idx_c   = (state_q == IDLE) ? bus.paddr_i[ADDR_W-1:2] : idx_q;
        cur_write_c = (state_q == IDLE) ? bus.pwrite_i : write_q;
        in_range_c  = ({1'b0, cur_idx_c} < IDX_EXT_W'(NUM_REGS));
        rdata_c     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_idx_c == IDX_W'(i)) begin
                rdata_c = bank_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state and next registered response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (!access_c) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // RESP always exits after one cycle, so this fires only on entry.
        if (state_d == RESP) begin
            pready_d  = 1'b1;
            pslverr_d = !in_range_c;
            prdata_d  = (!cur_write_c && in_range_c) ? rdata_c : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            bank_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (capture_c) begin
                idx_q   <= bus.paddr_i[ADDR_W-1:2];
                write_q <= bus.pwrite_i;
                wdata_q <= bus.pwdata_i;
                strb_q  <= bus_strb_c;
            end
            // Write commit on the edge leaving RESP.
            if ((state_q == RESP) && write_q && in_range_c) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (strb_q[b]) begin
                                bank_q[i*DATA_W + b*8 +: 8] <= wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.prdata_o  = prdata_q;
    assign bus.pready_o  = pready_q;
    assign bus.pslverr_o = pslverr_q;
    assign regs_o        = bank_q;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: three instances with WAIT_CYCLES = 0, 3 and 5.
`timescale 1ns/1ps
module tb_apb_regbank_slave;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NR = 16;
    localparam int unsigned BW = NR * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    psel;
    logic [2:0]    penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
`ifdef APB_REGBANK_PSTRB_EN
    logic [DW/8-1:0] pstrb;
`endif
    logic [2:0]    pready;
    logic [2:0]    pslverr;
    logic [DW-1:0] prdata [3];
    logic [BW-1:0] regs [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        apb_regbank_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.psel_i    = psel[g];
        assign bus.penable_i = penable[g];
        assign bus.paddr_i   = paddr;
        assign bus.pwrite_i  = pwrite;
        assign bus.pwdata_i  = pwdata;
`ifdef APB_REGBANK_PSTRB_EN
        assign bus.pstrb_i   = pstrb;
`endif
        assign pready[g]  = bus.pready_o;
        assign pslverr[g] = bus.pslverr_o;
        assign prdata[g]  = bus.prdata_o;
        apb_regbank_slave #(
            .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .WAIT_CYCLES(WC)
        ) u_dut (
            .clk(clk), .reset(reset), .bus(bus), .regs_o(regs[g])
        );
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full APB transfer on instance d; lat counts cycles from access phase to pready (40 = timeout).
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output logic [DW-1:0] rd,
                        output logic err, output int lat);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        penable[d] = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (pready[d]) break;
        end
        rd  = prdata[d];
        err = pslverr[d];
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            lat;
        int            hits;
        logic [BW-1:0] exp0;

        reset = 1'b0; psel = '0; penable = '0;
        paddr = '0; pwrite = 1'b0; pwdata = '0;
`ifdef APB_REGBANK_PSTRB_EN
        pstrb = '1;
`endif
        exp0 = '0;
        repeat (3) @(negedge clk);
        check("rst_pready", pready, 3'b000);
        check("rst_pslverr", pslverr, 3'b000);
        check("rst_prdata0", prdata[0], 32'h0);
        check("rst_regs0", regs[0], '0);
        check("rst_regs2", regs[2], '0);
        reset = 1'b1;
        @(negedge clk);

        // WAIT_CYCLES = 0: basic write / read
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, rd, err, lat);
        check("w0_wr_lat", lat, 1);
        check("w0_wr_err", err, 1'b0);
        check("w0_wr_prdata", rd, 32'h0);
        exp0[2*DW +: DW] = 32'hDEADBEEF;
        @(negedge clk);
        check("w0_wr_visible", regs[0], exp0);
        check("w0_ready_one_cycle", pready[0], 1'b0);

        xfer(0, 1'b0, 8'h08, 32'h0, rd, err, lat);
        check("w0_rd_lat", lat, 1);
        check("w0_rd_data", rd, 32'hDEADBEEF);
        check("w0_rd_err", err, 1'b0);
        @(negedge clk);
        check("w0_prdata_cleared", prdata[0], 32'h0);

        // out-of-range index 16
        xfer(0, 1'b1, 8'h40, 32'h12345678, rd, err, lat);
        check("w0_oor_wr_err", err, 1'b1);
        check("w0_oor_wr_lat", lat, 1);
        @(negedge clk);
        check("w0_oor_wr_nochange", regs[0], exp0);
        check("w0_pslverr_cleared", pslverr[0], 1'b0);
        xfer(0, 1'b0, 8'h40, 32'h0, rd, err, lat);
        check("w0_oor_rd_data", rd, 32'h0);
        check("w0_oor_rd_err", err, 1'b1);
        xfer(0, 1'b0, 8'hFC, 32'h0, rd, err, lat);
        check("w0_oor_top_err", err, 1'b1);

        // last valid index and ignored byte-offset bits
        xfer(0, 1'b1, 8'h3C, 32'hA5A50F0F, rd, err, lat);
        check("w0_top_wr_err", err, 1'b0);
        exp0[15*DW +: DW] = 32'hA5A50F0F;
        xfer(0, 1'b0, 8'h3C, 32'h0, rd, err, lat);
        check("w0_top_rd_data", rd, 32'hA5A50F0F);
        xfer(0, 1'b1, 8'h07, 32'hCAFEF00D, rd, err, lat);
        exp0[1*DW +: DW] = 32'hCAFEF00D;
        xfer(0, 1'b0, 8'h04, 32'h0, rd, err, lat);
        check("w0_offset_rd_data", rd, 32'hCAFEF00D);
        @(negedge clk);
        check("w0_bank", regs[0], exp0);

`ifdef APB_REGBANK_PSTRB_EN
        pstrb = 4'hF;
        xfer(0, 1'b1, 8'h04, 32'hFFFFFFFF, rd, err, lat);
        pstrb = 4'b0101;
        xfer(0, 1'b1, 8'h04, 32'h00000000, rd, err, lat);
        check("strb_wr_err", err, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, rd, err, lat);
        check("strb_rd_data", rd, 32'hFF00FF00);
        pstrb = 4'b0000;
        xfer(0, 1'b1, 8'h04, 32'h12345678, rd, err, lat);
        check("strb0_err", err, 1'b0);
        xfer(0, 1'b0, 8'h04, 32'h0, rd, err, lat);
        check("strb0_rd_data", rd, 32'hFF00FF00);
        pstrb = 4'hF;
`endif

        // WAIT_CYCLES = 3
        xfer(1, 1'b0, 8'h04, 32'h0, rd, err, lat);
        check("w3_rd_lat", lat, 4);
        check("w3_rd_data", rd, 32'h0);
        check("w3_rd_err", err, 1'b0);
        @(negedge clk);
        check("w3_ready_one_cycle", pready[1], 1'b0);
        xfer(1, 1'b1, 8'h04, 32'h0BADCAFE, rd, err, lat);
        check("w3_wr_lat", lat, 4);
        xfer(1, 1'b0, 8'h04, 32'h0, rd, err, lat);
        check("w3_rd2_data", rd, 32'h0BADCAFE);

        // WAIT_CYCLES = 5: protocol abort
        xfer(2, 1'b1, 8'h0C, 32'h11111111, rd, err, lat);
        check("w5_wr_lat", lat, 6);
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h22222222;
        @(negedge clk);
        penable[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        psel[2] = 1'b0; penable[2] = 1'b0;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (pready[2]) hits++;
        end
        check("w5_abort_no_ready", hits, 0);
        check("w5_abort_nochange", regs[2][3*DW +: DW], 32'h11111111);
        xfer(2, 1'b0, 8'h0C, 32'h0, rd, err, lat);
        check("w5_after_abort_lat", lat, 6);
        check("w5_after_abort_data", rd, 32'h11111111);

        // WAIT_CYCLES = 5: reset in the middle of a write
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h33333333;
        @(negedge clk);
        penable[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hits = 0;
        repeat (2) begin
            @(negedge clk);
            if (pready[2]) hits++;
        end
        psel[2] = 1'b0; penable[2] = 1'b0;
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (pready[2]) hits++;
        end
        check("w5_reset_no_ready", hits, 0);
        check("w5_reset_bank", regs[2], '0);
        check("w0_reset_bank", regs[0], '0);
        xfer(2, 1'b1, 8'h10, 32'h44444444, rd, err, lat);
        check("w5_post_rst_wr_lat", lat, 6);
        check("w5_post_rst_wr_err", err, 1'b0);
        xfer(2, 1'b0, 8'h10, 32'h0, rd, err, lat);
        check("w5_post_rst_rd_data", rd, 32'h44444444);
        xfer(0, 1'b0, 8'h08, 32'h0, rd, err, lat);
        check("w0_post_rst_rd_data", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
